// File: rtl/ex_mul_pkg.sv
// Shared constants for the EX-stage iterative multiplier: widths, FSM state codes,
// the op_signed encoding and the operand-magnitude helper.
package ex_mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int CNT_WIDTH = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OP_UNSIGNED = 1'b0;
  localparam logic OP_SIGNED   = 1'b1;

  // 0x80000000 maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [MUL_WIDTH-1:0] magnitude(input logic [MUL_WIDTH-1:0] x,
                                                     input logic op);
    return ((op == OP_SIGNED) && x[MUL_WIDTH-1]) ? (~x + MUL_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/ex_mul_core.sv
// Shift-add datapath: one multiplier bit per step, product negated on output when signs differ.
// EX_MUL_EARLY_TERM_EN drives 'last' once the remaining multiplier bits are zero; otherwise 'last' stays 0.
module ex_mul_core
  import ex_mul_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic                   op_signed,
  input  logic [MUL_WIDTH-1:0]   a,
  input  logic [MUL_WIDTH-1:0]   b,
  output logic                   last,
  output logic [2*MUL_WIDTH-1:0] prod
);

  logic [2*MUL_WIDTH-1:0] mcand;
  logic [2*MUL_WIDTH-1:0] acc;
  logic [MUL_WIDTH-1:0]   mplier;
  logic                   neg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= {{MUL_WIDTH{1'b0}}, magnitude(a, op_signed)};
      mplier <= magnitude(b, op_signed);
      acc    <= '0;
      neg    <= (op_signed == OP_SIGNED) && (a[MUL_WIDTH-1] ^ b[MUL_WIDTH-1]);
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

`ifdef EX_MUL_EARLY_TERM_EN
  // True in the cycle whose step consumes the last set multiplier bit.
  assign last = (mplier[MUL_WIDTH-1:1] == '0);
`else
  assign last = 1'b0;
`endif

  assign prod = neg ? (~acc + 64'd1) : acc;

endmodule

// File: rtl/ex_mul_unit.sv
// EX-stage multiplier control: IDLE/BUSY/DONE FSM, step counter and pipeline stall; done 33 cycles after start.
// Optional EX_MUL_EARLY_TERM_EN shortens BUSY when the multiplier runs out of set bits.
module ex_mul_unit
  import ex_mul_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 op_signed,
  input  logic [MUL_WIDTH-1:0] a_in,
  input  logic [MUL_WIDTH-1:0] b_in,
  input  logic                 flush,
  output logic                 stall_out,
  output logic                 busy,
  output logic                 done,
  output logic [MUL_WIDTH-1:0] result_hi,
  output logic [MUL_WIDTH-1:0] result_lo
);

  logic [1:0]             state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [MUL_WIDTH-1:0]   res_hi_q;
  logic [MUL_WIDTH-1:0]   res_lo_q;
  logic [2*MUL_WIDTH-1:0] prod;
  logic                   accept;
  logic                   last;
  logic                   finish;

  assign accept = (state == S_IDLE) && start && !flush;
  assign finish = (cnt == CNT_WIDTH'(MUL_WIDTH - 1)) || last;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state <= S_BUSY;
          cnt   <= '0;
        end
        S_BUSY: begin
          if (flush)       state <= S_IDLE;
          else if (finish) state <= S_DONE;
          else             cnt   <= cnt + CNT_WIDTH'(1);
        end
        S_DONE: begin
          // The product is committed only if DONE was not aborted.
          state <= S_IDLE;
          if (!flush) {res_hi_q, res_lo_q} <= prod;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  ex_mul_core u_core (
    .clk      (Clk),
    .reset    (Reset),
    .load     (accept),
    .step     (state == S_BUSY),
    .op_signed(op_signed),
    .a        (a_in),
    .b        (b_in),
    .last     (last),
    .prod     (prod)
  );

  assign busy      = (state == S_BUSY);
  assign done      = (state == S_DONE) && !flush;
  assign stall_out = busy || accept;
  // During DONE the fresh product is visible alongside the done pulse.
  assign {result_hi, result_lo} = (state == S_DONE) ? prod : {res_hi_q, res_lo_q};

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed self-checking bench for ex_mul_unit; latencies follow EX_MUL_EARLY_TERM_EN when defined.
module tb_ex_mul_unit;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic        op_signed;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flush;
  logic        stall_out;
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  int checks = 0;
  int errors = 0;

`ifdef EX_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  ex_mul_unit dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .op_signed(op_signed),
    .a_in     (a_in),
    .b_in     (b_in),
    .flush    (flush),
    .stall_out(stall_out),
    .busy     (busy),
    .done     (done),
    .result_hi(result_hi),
    .result_lo(result_lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int exp_lat(input int full, input int early);
    return EARLY ? early : full;
  endfunction

  // Drives one start at cycle N and watches cycles N+1..N+45. Optional injected start,
  // flush or reset at a given BUSY cycle k. lat = first k with done (0 if none).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int inj_at, input int flush_at, input int rst_at,
                        output int lat, output int ndone, output logic stall_bad,
                        output logic abort_busy);
    int   abort_k;
    logic active;
    lat = 0; ndone = 0; stall_bad = 1'b0; abort_busy = 1'b0; active = 1'b1;
    abort_k = (flush_at != 0) ? flush_at : rst_at;
    a_in = a; b_in = b; op_signed = s; start = 1'b1;
    #1;
    if (stall_out !== 1'b1) stall_bad = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      flush = (k == flush_at);
      Reset = !(k == rst_at);
      start = (k == inj_at);
      if (k == inj_at) begin a_in = 32'd1; b_in = 32'd1; end
      #1;
      if (abort_k != 0 && k == abort_k + 1) abort_busy = busy;
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) lat = k;
      end
      if (stall_out !== (active && (done !== 1'b1))) stall_bad = 1'b1;
      if (done === 1'b1 || k == flush_at || k == rst_at) active = 1'b0;
      @(posedge Clk); #1;
      flush = 1'b0; Reset = 1'b1; start = 1'b0;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; start = 1'b0; flush = 1'b0; op_signed = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_out); end
    checks++; if (result_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", result_hi); end
    checks++; if (result_lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", result_lo); end
    @(posedge Clk); #1;
  endtask

  task automatic test_unsigned;
    int lat, nd; logic sb, ab;
    run_op(32'd3, 32'd5, 1'b0, 0, 0, 0, lat, nd, sb, ab);
    checks++; if (lat !== exp_lat(33, 4)) begin errors++; $display("FAIL u3x5_latency got %0d want %0d", lat, exp_lat(33, 4)); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL u3x5_done_count got %0d want 1", nd); end
    checks++; if (sb !== 1'b0) begin errors++; $display("FAIL u3x5_stall_profile got bad=%b want 0", sb); end
    checks++; if (result_hi !== 32'h0) begin errors++; $display("FAIL u3x5_hi got %h want 00000000", result_hi); end
    checks++; if (result_lo !== 32'hF) begin errors++; $display("FAIL u3x5_lo got %h want 0000000f", result_lo); end
  endtask

  task automatic test_signed;
    int lat, nd; logic sb, ab;
    run_op(32'hFFFF_FFFE, 32'h7, 1'b1, 0, 0, 0, lat, nd, sb, ab);
    checks++; if (lat !== exp_lat(33, 4)) begin errors++; $display("FAIL sneg2x7_latency got %0d want %0d", lat, exp_lat(33, 4)); end
    checks++; if (result_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sneg2x7_hi got %h want ffffffff", result_hi); end
    checks++; if (result_lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL sneg2x7_lo got %h want fffffff2", result_lo); end
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 0, lat, nd, sb, ab);
    checks++; if (lat !== 33) begin errors++; $display("FAIL smin_sq_latency got %0d want 33", lat); end
    checks++; if (result_hi !== 32'h4000_0000) begin errors++; $display("FAIL smin_sq_hi got %h want 40000000", result_hi); end
    checks++; if (result_lo !== 32'h0) begin errors++; $display("FAIL smin_sq_lo got %h want 00000000", result_lo); end
    run_op(32'h8000_0000, 32'h2, 1'b0, 0, 0, 0, lat, nd, sb, ab);
    checks++; if (result_hi !== 32'h1) begin errors++; $display("FAIL u8000x2_hi got %h want 00000001", result_hi); end
    checks++; if (result_lo !== 32'h0) begin errors++; $display("FAIL u8000x2_lo got %h want 00000000", result_lo); end
  endtask

  task automatic test_back_to_back;
    int lat, nd; logic sb, ab;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, 0, 0, lat, nd, sb, ab);
    checks++; if (lat !== 33) begin errors++; $display("FAIL umax_latency got %0d want 33", lat); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL umax_ignored_start got %0d done pulses want 1", nd); end
    checks++; if (sb !== 1'b0) begin errors++; $display("FAIL umax_stall_profile got bad=%b want 0", sb); end
    checks++; if (result_hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umax_hi got %h want fffffffe", result_hi); end
    checks++; if (result_lo !== 32'h0000_0001) begin errors++; $display("FAIL umax_lo got %h want 00000001", result_lo); end
  endtask

  task automatic test_flush;
    int lat, nd; logic sb, ab;
    run_op(32'd7, 32'h8000_0001, 1'b0, 0, 10, 0, lat, nd, sb, ab);
    checks++; if (nd !== 0) begin errors++; $display("FAIL flush_no_done got %0d pulses want 0", nd); end
    checks++; if (ab !== 1'b0) begin errors++; $display("FAIL flush_idle_next got busy=%b want 0", ab); end
    checks++; if (sb !== 1'b0) begin errors++; $display("FAIL flush_stall_profile got bad=%b want 0", sb); end
    checks++; if (result_hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL flush_hold_hi got %h want fffffffe", result_hi); end
    checks++; if (result_lo !== 32'h0000_0001) begin errors++; $display("FAIL flush_hold_lo got %h want 00000001", result_lo); end
  endtask

  task automatic test_reset_mid;
    int lat, nd; logic sb, ab;
    run_op(32'd5, 32'h8000_0003, 1'b0, 0, 0, 20, lat, nd, sb, ab);
    checks++; if (nd !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses want 0", nd); end
    checks++; if (ab !== 1'b0) begin errors++; $display("FAIL rstmid_idle_next got busy=%b want 0", ab); end
    checks++; if (result_hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi got %h want 00000000", result_hi); end
    checks++; if (result_lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo got %h want 00000000", result_lo); end
  endtask

  task automatic test_flush_start_idle;
    int nd;
    nd = 0;
    a_in = 32'd9; b_in = 32'd9; op_signed = 1'b0; start = 1'b1; flush = 1'b1;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL idleflush_stall got %b want 0", stall_out); end
    @(posedge Clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idleflush_busy got %b want 0", busy); end
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) nd++;
      @(posedge Clk); #1;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL idleflush_no_done got %0d pulses want 0", nd); end
  endtask

  task automatic test_early_term;
    int lat, nd; logic sb, ab;
    run_op(32'd7, 32'd0, 1'b0, 0, 0, 0, lat, nd, sb, ab);
    checks++; if (lat !== exp_lat(33, 2)) begin errors++; $display("FAIL et7x0_latency got %0d want %0d", lat, exp_lat(33, 2)); end
    checks++; if ({result_hi, result_lo} !== 64'h0) begin errors++; $display("FAIL et7x0_result got %h%h want 0", result_hi, result_lo); end
    run_op(32'd7, 32'd1, 1'b0, 0, 0, 0, lat, nd, sb, ab);
    checks++; if (lat !== exp_lat(33, 2)) begin errors++; $display("FAIL et7x1_latency got %0d want %0d", lat, exp_lat(33, 2)); end
    checks++; if (result_lo !== 32'd7) begin errors++; $display("FAIL et7x1_lo got %h want 00000007", result_lo); end
    checks++; if (sb !== 1'b0) begin errors++; $display("FAIL et7x1_stall_profile got bad=%b want 0", sb); end
    run_op(32'd7, 32'h8000_0000, 1'b0, 0, 0, 0, lat, nd, sb, ab);
    checks++; if (lat !== 33) begin errors++; $display("FAIL et7xmsb_latency got %0d want 33", lat); end
    checks++; if (result_hi !== 32'h3) begin errors++; $display("FAIL et7xmsb_hi got %h want 00000003", result_hi); end
    checks++; if (result_lo !== 32'h8000_0000) begin errors++; $display("FAIL et7xmsb_lo got %h want 80000000", result_lo); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_flush_start_idle();
    test_early_term();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mul_unit.md
EX_MUL_UNIT -- requirements
Module: ex_mul_unit

Interface
REQ-001 SHALL have port Clk  input  1  single clock; all state updates on posedge Clk.
REQ-002 SHALL have port Reset  input  1  synchronous, active-low reset, sampled on posedge Clk.
REQ-003 SHALL have port start  input  1  multiply request from ID/EX stage outputs, valid for one cycle.
REQ-004 SHALL have port op_signed  input  1  1 = signed multiply, 0 = unsigned multiply; sampled with start.
REQ-005 SHALL have port a_in  input  32  multiplicand (ID/EX read_data_1_out).
REQ-006 SHALL have port b_in  input  32  multiplier (ID/EX read_data_2_out).
REQ-007 SHALL have port flush  input  1  abort request from branch/jump resolution.
REQ-008 SHALL have port stall_out  output  1  holds PC, IF/ID and ID/EX (drives ID_EXWrite path) while the multiply is pending.
REQ-009 SHALL have port busy  output  1  high while state is BUSY.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-011 SHALL have port result_hi  output  32  upper product word (HI).
REQ-012 SHALL have port result_lo  output  32  lower product word (LO).

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 IDLE with start=1 and flush=0 SHALL latch a_in, b_in and op_signed, then enter BUSY.
REQ-015 Signed operands SHALL be converted to magnitudes at latch time, and sign = a[31] XOR b[31] SHALL be recorded; abs(0x80000000) = 0x80000000 as unsigned.
REQ-016 BUSY SHALL perform one shift-add step per cycle on a 64-bit accumulator, driven by a 6-bit step counter that starts at 0.
REQ-017 Without the REQ-030 macro, BUSY SHALL last exactly 32 cycles; the cycle with counter=31 SHALL transition to DONE.
REQ-018 DONE SHALL last one cycle, assert done=1, load result_hi/result_lo (two's-complement negated when sign=1), then return to IDLE.
REQ-019 Latency: start accepted at edge N SHALL give done=1 during cycle N+33, with results valid from the same edge.
REQ-020 result_hi/result_lo SHALL hold their value until the next DONE or reset.
REQ-021 stall_out SHALL equal (state==BUSY) OR (state==IDLE AND start AND NOT flush); it SHALL be 0 in DONE.
REQ-022 start during BUSY or DONE SHALL be ignored.
REQ-023 flush in BUSY or DONE SHALL return the FSM to IDLE next edge, with no done pulse and result registers unchanged.
REQ-024 flush and start together in IDLE: flush SHALL win, with no operation started.
REQ-025 Unsigned 0xFFFFFFFF*0xFFFFFFFF SHALL yield 0xFFFFFFFE_00000001; the accumulator SHALL carry into bit 63 without loss.

Reset
REQ-026 Reset=0 at a posedge SHALL force state IDLE and the counter to 0.
REQ-027 Reset=0 at a posedge SHALL clear the accumulator and latched operands.
REQ-028 Reset=0 at a posedge SHALL set result_hi=0, result_lo=0, done=0 and busy=0.
REQ-029 Reset mid-operation SHALL abort with no done pulse; Reset SHALL take priority over flush and start.

Configuration
REQ-030 Macro EX_MUL_EARLY_TERM_EN defined: BUSY SHALL exit to DONE after any step that leaves the remaining multiplier bits all zero; minimum BUSY is 1 cycle (b=0 gives done during N+2).
REQ-031 Macro EX_MUL_EARLY_TERM_EN undefined: latency SHALL be fixed per REQ-017/REQ-019.
REQ-032 Results SHALL be identical with and without the macro.

Structure
REQ-033 Shared package ex_mul_pkg SHALL hold the state enum (IDLE/BUSY/DONE), MUL_WIDTH=32, CNT_WIDTH=6 and the signed/unsigned op encoding.
REQ-034 The shift-add datapath (accumulator, shifted multiplicand, final negate) SHALL be sub-module ex_mul_core; the FSM, counter and stall logic SHALL stay in ex_mul_unit.

Verification
REQ-035 Reset=0 for 2 cycles, then release -> all outputs 0, state IDLE, stall_out=0.
REQ-036 Unsigned 3*5 start at N -> stall_out=1 during N..N+32, done=1 during N+33, hi=0x00000000, lo=0x0000000F.
REQ-037 Signed 0xFFFFFFFE * 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFF2; signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
REQ-038 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; second start during BUSY is ignored and the result is unchanged.
REQ-039 Flush at BUSY cycle 10, and separately Reset=0 at BUSY cycle 20 -> no done pulse, IDLE next edge, result regs keep prior value (flush) or 0 (reset).
REQ-040 With EX_MUL_EARLY_TERM_EN: 7*0 -> done during N+2; 7*1 -> done during N+2, lo=7; 7*0x80000000 -> done during N+33.
